// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// op encodings, FSM state enum and the default operand width.
package muldiv_pkg;

   localparam int MULDIV_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration, purely combinational.
//  multiply: shift-add, acc holds the running high half, shreg the multiplier
//            (low product bits shift in from the top).
//  divide:   restoring, acc holds the partial remainder, shreg the dividend
//            bits still to consume with quotient bits shifting in at the bottom.
import muldiv_pkg::*;

module muldiv_step #(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH-1:0] shreg,
   input  logic [WIDTH-1:0] operand,
   input  logic             is_div,
   output logic [WIDTH:0]   acc_nx,
   output logic [WIDTH-1:0] shreg_nx
);

   logic [WIDTH:0] w_opnd_ext;
   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_add;
   logic [WIDTH:0] w_rem_sh;
   logic [WIDTH:0] w_diff;

   assign w_opnd_ext = {1'b0, operand};
   assign w_sum      = acc + w_opnd_ext;
   assign w_add      = shreg[0] ? w_sum : acc;
   assign w_rem_sh   = {acc[WIDTH-1:0], shreg[WIDTH-1]};
   assign w_diff     = w_rem_sh - w_opnd_ext;

   // Select the multiply or divide iteration result.
   always_comb begin
      acc_nx   = acc;
      shreg_nx = shreg;
      if (is_div) begin
         if (w_rem_sh >= w_opnd_ext) begin
            acc_nx   = w_diff;
            shreg_nx = {shreg[WIDTH-2:0], 1'b1};
         end else begin
            acc_nx   = w_rem_sh;
            shreg_nx = {shreg[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_nx   = {1'b0, w_add[WIDTH:1]};
         shreg_nx = {w_add[0], shreg[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer with HI/LO registers.
// Optional build macro MULDIV_EARLY_OUT_EN: a zero rt_val at accept skips
// the iteration phase (FIX at cycle 1, done at cycle 2). Without it the
// latency is always WIDTH+2 cycles.
//
//  state | meaning
//  IDLE  | waiting for start; MTHI/MTLO honoured
//  CALC  | one shift-add / restoring step per clock, WIDTH steps
//  FIX   | sign correction; HI/LO written at the end of this cycle
//  DONE  | done pulse; new start or MTHI/MTLO accepted
import muldiv_pkg::*;

module muldiv_seq #(
   parameter int WIDTH = MULDIV_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e             r_state;
   state_e             w_state_nx;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH:0]     r_acc;
   logic [WIDTH-1:0]   r_shreg;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_rs_raw;
   logic               r_is_div;
   logic               r_neg_res;
   logic               r_neg_rem;
   logic               r_dbz;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_idle_or_done;
   logic               w_accept;
   logic               w_signed;
   logic               w_is_div;
   logic               w_rs_neg;
   logic               w_rt_neg;
   logic [WIDTH-1:0]   w_rs_abs;
   logic [WIDTH-1:0]   w_rt_abs;
   logic               w_rt_zero;
   logic               w_skip;
   logic [WIDTH:0]     w_acc_nx;
   logic [WIDTH-1:0]   w_shreg_nx;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;

   assign w_idle_or_done = (r_state == IDLE) || (r_state == DONE);
   assign w_accept       = start && w_idle_or_done;
   assign w_signed       = (op == OP_MULT) || (op == OP_DIV);
   assign w_is_div       = (op == OP_DIV) || (op == OP_DIVU);
   assign w_rs_neg       = w_signed && rs_val[WIDTH-1];
   assign w_rt_neg       = w_signed && rt_val[WIDTH-1];
   assign w_rs_abs       = w_rs_neg ? -rs_val : rs_val;
   assign w_rt_abs       = w_rt_neg ? -rt_val : rt_val;
   assign w_rt_zero      = (rt_val == '0);

`ifdef MULDIV_EARLY_OUT_EN
   assign w_skip = w_rt_zero;
`else
   assign w_skip = 1'b0;
`endif

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc      (r_acc),
      .shreg    (r_shreg),
      .operand  (r_opnd),
      .is_div   (r_is_div),
      .acc_nx   (w_acc_nx),
      .shreg_nx (w_shreg_nx)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nx;
   end

   // Next-state logic; DONE falls back to IDLE unless a new op is accepted.
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nx = w_skip ? FIX : CALC;
         CALC:    if (r_cnt == '0) w_state_nx = FIX;
         FIX:     w_state_nx = DONE;
         DONE:    w_state_nx = w_accept ? (w_skip ? FIX : CALC) : IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   // Status outputs decoded from state.
   always_comb begin
      busy = (r_state == CALC) || (r_state == FIX);
      done = (r_state == DONE);
   end

   // Operand latch at accept, one iteration per CALC cycle.
   // Multiply iterates the multiplier (rt) in shreg; divide iterates the dividend (rs).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_shreg   <= '0;
         r_opnd    <= '0;
         r_rs_raw  <= '0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_dbz     <= 1'b0;
      end else if (w_accept) begin
         r_cnt     <= CNT_W'(WIDTH - 1);
         r_acc     <= '0;
         r_shreg   <= w_is_div ? w_rs_abs : w_rt_abs;
         r_opnd    <= w_is_div ? w_rt_abs : w_rs_abs;
         r_rs_raw  <= rs_val;
         r_is_div  <= w_is_div;
         r_neg_res <= w_rs_neg ^ w_rt_neg;
         r_neg_rem <= w_rs_neg;
         r_dbz     <= w_is_div && w_rt_zero;
      end else if (r_state == CALC) begin
         r_acc   <= w_acc_nx;
         r_shreg <= w_shreg_nx;
         if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
   end

   assign w_prod = {r_acc[WIDTH-1:0], r_shreg};

   // Sign correction of the unsigned result; divide-by-zero bypasses it
   // so HI returns the dividend exactly as sampled.
   always_comb begin
      {w_res_hi, w_res_lo} = w_prod;
      if (!r_is_div) begin
         {w_res_hi, w_res_lo} = r_neg_res ? -w_prod : w_prod;
      end else if (r_dbz) begin
         w_res_hi = r_rs_raw;
         w_res_lo = '1;
      end else begin
         w_res_lo = r_neg_res ? -r_shreg : r_shreg;
         w_res_hi = r_neg_rem ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      end
   end

   // HI/LO: result at end of FIX, MTHI/MTLO only when not busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (r_state == FIX) begin
         r_hi <= w_res_hi;
         r_lo <= w_res_lo;
      end else if (w_idle_or_done) begin
         if (hi_we) r_hi <= wdata;
         if (lo_we) r_lo <= wdata;
      end
   end

   assign hi = r_hi;
   assign lo = r_lo;

endmodule
